// File: rtl/ex_stage_if.sv
// ex_stage_if: handshake and datapath bundle between the ID/EX register,
// the EX stage and the EX/MEM register. Signal suffixes (_i/_o) are named
// from the EX stage's point of view: the master drives the _i signals and
// observes the _o signals, the slave (ex_stage) does the opposite.
interface ex_stage_if;
    logic        ex_valid_i;
    logic        mem_allowin_i;
    logic        flush_i;
    logic [31:0] pc_i;
    logic [3:0]  alu_op_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [4:0]  dest_i;
    logic        gr_we_i;

    logic        ex_allowin_o;
    logic        ex_to_mem_valid_o;
    logic [31:0] pc_o;
    logic [4:0]  dest_o;
    logic        gr_we_o;
    logic [31:0] result_o;

    modport master (
        output ex_valid_i, mem_allowin_i, flush_i, pc_i, alu_op_i,
               src1_i, src2_i, dest_i, gr_we_i,
        input  ex_allowin_o, ex_to_mem_valid_o, pc_o, dest_o, gr_we_o,
               result_o
    );

    modport slave (
        input  ex_valid_i, mem_allowin_i, flush_i, pc_i, alu_op_i,
               src1_i, src2_i, dest_i, gr_we_i,
        output ex_allowin_o, ex_to_mem_valid_o, pc_o, dest_o, gr_we_o,
               result_o
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the pipeline. Single-cycle ALU for ops 0..11
// and, when the EX_DIV_EN macro is defined, a 32-step restoring divider for
// ops 12..15 (DIV.W, MOD.W, DIV.WU, MOD.WU). Without EX_DIV_EN the divide
// opcodes complete in one cycle with a zero result.
// Clock clk, synchronous active-low reset rst_n.
module ex_stage (
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;

    logic [4:0]  shamt;
    logic [31:0] aluResult;
    logic        readyGo;
    logic [31:0] exResult;

    assign shamt = bus.src2_i[4:0];

    // Single-cycle ALU; divide opcodes fall through to zero here and are
    // overridden by the divider result when it is built.
    always_comb begin
        aluResult = '0;
        case (bus.alu_op_i)
            OP_ADD:  aluResult = bus.src1_i + bus.src2_i;
            OP_SUB:  aluResult = bus.src1_i - bus.src2_i;
            OP_SLT:  aluResult = {31'd0, $signed(bus.src1_i) < $signed(bus.src2_i)};
            OP_SLTU: aluResult = {31'd0, bus.src1_i < bus.src2_i};
            OP_AND:  aluResult = bus.src1_i & bus.src2_i;
            OP_OR:   aluResult = bus.src1_i | bus.src2_i;
            OP_NOR:  aluResult = ~(bus.src1_i | bus.src2_i);
            OP_XOR:  aluResult = bus.src1_i ^ bus.src2_i;
            OP_SLL:  aluResult = bus.src1_i << shamt;
            OP_SRL:  aluResult = bus.src1_i >> shamt;
            OP_SRA:  aluResult = $signed(bus.src1_i) >>> shamt;
            OP_LUI:  aluResult = bus.src2_i;
            default: aluResult = '0;
        endcase
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } divState_e;

    divState_e   state_q;
    logic [4:0]  count_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] divisor_q;
    logic        quoNeg_q;
    logic        remNeg_q;
    logic        isMod_q;
    logic        divZero_q;

    logic        divOp;
    logic        signedOp;
    logic        src1Neg;
    logic        src2Neg;
    logic [31:0] absSrc1;
    logic [31:0] absSrc2;
    logic        startDiv;
    logic [32:0] remShift;
    logic [32:0] trial;
    logic [31:0] quo_d;
    logic [31:0] rem_d;
    logic [31:0] quoFinal;
    logic [31:0] remFinal;
    logic [31:0] divResult;

    // Ops 12..15 share the 2'b11 prefix; bit 1 selects unsigned, bit 0 selects remainder.
    assign divOp    = (bus.alu_op_i[3:2] == 2'b11);
    assign signedOp = ~bus.alu_op_i[1];
    assign src1Neg  = signedOp & bus.src1_i[31];
    assign src2Neg  = signedOp & bus.src2_i[31];
    assign absSrc1  = src1Neg ? (32'd0 - bus.src1_i) : bus.src1_i;
    assign absSrc2  = src2Neg ? (32'd0 - bus.src2_i) : bus.src2_i;
    assign startDiv = bus.ex_valid_i & divOp & ~bus.flush_i;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if it did not borrow.
    always_comb begin
        remShift = {rem_q, quo_q[31]};
        trial    = remShift - {1'b0, divisor_q};
        quo_d    = {quo_q[30:0], ~trial[32]};
        rem_d    = trial[32] ? remShift[31:0] : trial[31:0];
    end

    // Divider FSM: latch operand magnitudes, iterate 32 steps, then hold
    // the result until MEM takes it; flush or reset abandons the op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            quoNeg_q  <= 1'b0;
            remNeg_q  <= 1'b0;
            isMod_q   <= 1'b0;
            divZero_q <= 1'b0;
        end else if (bus.flush_i) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startDiv) begin
                        state_q   <= CALC;
                        count_q   <= '0;
                        quo_q     <= absSrc1;
                        rem_q     <= '0;
                        divisor_q <= absSrc2;
                        quoNeg_q  <= src1Neg ^ src2Neg;
                        remNeg_q  <= src1Neg;
                        isMod_q   <= bus.alu_op_i[0];
                        divZero_q <= (bus.src2_i == 32'd0);
                    end
                end
                CALC: begin
                    quo_q   <= quo_d;
                    rem_q   <= rem_d;
                    count_q <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.mem_allowin_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sign fix-up of the registered magnitudes; divide by zero always
    // reports an all-ones quotient regardless of signedness.
    always_comb begin
        quoFinal  = quoNeg_q ? (32'd0 - quo_q) : quo_q;
        remFinal  = remNeg_q ? (32'd0 - rem_q) : rem_q;
        if (divZero_q) begin
            quoFinal = 32'hFFFF_FFFF;
        end
        divResult = isMod_q ? remFinal : quoFinal;
    end

    assign readyGo  = divOp ? (state_q == DONE) : 1'b1;
    assign exResult = divOp ? divResult : aluResult;
`else
    assign readyGo  = 1'b1;
    assign exResult = aluResult;
`endif

    assign bus.ex_to_mem_valid_o = bus.ex_valid_i & readyGo & ~bus.flush_i;
    assign bus.ex_allowin_o      = ~bus.ex_valid_i | (readyGo & bus.mem_allowin_i) | bus.flush_i;
    assign bus.result_o          = exResult;
    assign bus.pc_o              = bus.pc_i;
    assign bus.dest_o            = bus.dest_i;
    assign bus.gr_we_o           = bus.gr_we_i;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed testbench for ex_stage. ALU, handshake and
// pass-through vectors always run; divider vectors run when EX_DIV_EN is
// defined, otherwise the single-cycle zero-result behaviour is checked.
`timescale 1ns/1ps
module tb_ex_stage;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SLTU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_LUI  = 4'd11;
    localparam logic [3:0] OP_DIVW  = 4'd12;
    localparam logic [3:0] OP_MODW  = 4'd13;
    localparam logic [3:0] OP_DIVWU = 4'd14;
    localparam logic [3:0] OP_MODWU = 4'd15;

    logic clk;
    logic rst_n;
    int   errCount;
    int   checkCount;

    ex_stage_if bus();

    ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic memAllow, input logic flush,
                                 input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        bus.ex_valid_i    = valid;
        bus.mem_allowin_i = memAllow;
        bus.flush_i       = flush;
        bus.alu_op_i      = op;
        bus.src1_i        = a;
        bus.src2_i        = b;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One single-cycle op: result and valid must appear in the same cycle.
    task automatic aluCase(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expected);
        applyStimulus(1'b1, 1'b1, 1'b0, op, a, b);
        @(negedge clk);
        checkOutput({tag, " result"}, bus.result_o, expected);
        checkOutput({tag, " valid"}, {31'd0, bus.ex_to_mem_valid_o}, 32'd1);
        nextCycle();
    endtask

`ifdef EX_DIV_EN
    // Called just after a rising edge (cycle 0); returns at the falling
    // edge of the first cycle with valid high, or -1 after the budget.
    task automatic waitValid(input int budget, output int seen, output logic [31:0] res,
                             output int allowinHigh);
        seen        = -1;
        res         = '0;
        allowinHigh = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            if (bus.ex_to_mem_valid_o) begin
                seen = cyc;
                res  = bus.result_o;
                break;
            end
            if (bus.ex_allowin_o) allowinHigh++;
            nextCycle();
        end
    endtask

    task automatic runDivide(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expected);
        int          seen;
        int          hi;
        logic [31:0] res;
        applyStimulus(1'b1, 1'b1, 1'b0, op, a, b);
        waitValid(40, seen, res, hi);
        checkOutput({tag, " latency"}, seen, 32'd33);
        checkOutput({tag, " result"}, res, expected);
        checkOutput({tag, " allowin while busy"}, hi, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, OP_ADD, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput({tag, " idle after"}, {30'd0, bus.ex_allowin_o, bus.ex_to_mem_valid_o}, 32'd2);
        nextCycle();
    endtask
`endif

    initial begin
        errCount   = 0;
        checkCount = 0;
        rst_n      = 1'b0;
        bus.pc_i   = 32'h1C00_0000;
        bus.dest_i = 5'd0;
        bus.gr_we_i = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, OP_ADD, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state with no valid instruction.
        @(negedge clk);
        checkOutput("reset allowin", {31'd0, bus.ex_allowin_o}, 32'd1);
        checkOutput("reset valid", {31'd0, bus.ex_to_mem_valid_o}, 32'd0);
        nextCycle();

        // Single-cycle ALU vectors.
        aluCase("ADD wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
        aluCase("SUB wrap", OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);
        aluCase("SLT neg", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
        aluCase("SLT pos", OP_SLT, 32'd5, 32'hFFFF_FFFE, 32'd0);
        aluCase("SLTU", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
        aluCase("SLTU lt", OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1);
        aluCase("AND", OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        aluCase("OR", OP_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
        aluCase("NOR", OP_NOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F);
        aluCase("XOR", OP_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
        aluCase("SLL 31", OP_SLL, 32'd1, 32'h0000_003F, 32'h8000_0000);
        aluCase("SRL 4", OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
        aluCase("SRA 4", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        aluCase("LUI", OP_LUI, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000);

        // Pass-through fields.
        bus.pc_i    = 32'h1C00_0040;
        bus.dest_i  = 5'd17;
        bus.gr_we_i = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, OP_ADD, 32'd3, 32'd4);
        @(negedge clk);
        checkOutput("pc pass", bus.pc_o, 32'h1C00_0040);
        checkOutput("dest pass", {27'd0, bus.dest_o}, 32'd17);
        checkOutput("gr_we pass", {31'd0, bus.gr_we_o}, 32'd1);
        bus.pc_i    = 32'h0000_0ABC;
        bus.dest_i  = 5'd2;
        bus.gr_we_i = 1'b0;
        #1;
        checkOutput("pc pass 2", bus.pc_o, 32'h0000_0ABC);
        checkOutput("dest pass 2", {27'd0, bus.dest_o}, 32'd2);
        checkOutput("gr_we pass 2", {31'd0, bus.gr_we_o}, 32'd0);
        nextCycle();

        // Handshake: MEM stall, flush, and empty stage.
        applyStimulus(1'b1, 1'b0, 1'b0, OP_ADD, 32'd1, 32'd1);
        @(negedge clk);
        checkOutput("stall allowin", {31'd0, bus.ex_allowin_o}, 32'd0);
        checkOutput("stall valid", {31'd0, bus.ex_to_mem_valid_o}, 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, OP_ADD, 32'd1, 32'd1);
        @(negedge clk);
        checkOutput("flush allowin", {31'd0, bus.ex_allowin_o}, 32'd1);
        checkOutput("flush valid", {31'd0, bus.ex_to_mem_valid_o}, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, OP_ADD, 32'd1, 32'd1);
        @(negedge clk);
        checkOutput("empty allowin", {31'd0, bus.ex_allowin_o}, 32'd1);
        checkOutput("empty valid", {31'd0, bus.ex_to_mem_valid_o}, 32'd0);
        nextCycle();

`ifdef EX_DIV_EN
        begin
            int          seen;
            int          hi;
            int          validCount;
            logic [31:0] res;

            runDivide("DIV.W -7/2", OP_DIVW, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
            runDivide("MOD.W -7/2", OP_MODW, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
            runDivide("DIV.W 7/-2", OP_DIVW, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
            runDivide("MOD.W 7/-2", OP_MODW, 32'd7, 32'hFFFF_FFFE, 32'd1);
            runDivide("DIV.WU 100/0", OP_DIVWU, 32'd100, 32'd0, 32'hFFFF_FFFF);
            runDivide("MOD.WU 100/0", OP_MODWU, 32'd100, 32'd0, 32'd100);
            runDivide("DIV.W -7/0", OP_DIVW, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
            runDivide("MOD.W -7/0", OP_MODW, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
            runDivide("DIV.W ovf", OP_DIVW, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
            runDivide("MOD.W ovf", OP_MODW, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
            runDivide("DIV.WU big", OP_DIVWU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);
            runDivide("MOD.WU big", OP_MODWU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F);

            // Stall in DONE, then release; the same op stays valid so the
            // next divide must restart from IDLE with full latency.
            applyStimulus(1'b1, 1'b0, 1'b0, OP_DIVW, 32'hFFFF_FFF9, 32'd2);
            waitValid(40, seen, res, hi);
            checkOutput("stall div latency", seen, 32'd33);
            checkOutput("stall div result", res, 32'hFFFF_FFFD);
            for (int k = 0; k < 5; k++) begin
                nextCycle();
                @(negedge clk);
                checkOutput("stall hold result", bus.result_o, 32'hFFFF_FFFD);
                checkOutput("stall hold allowin", {31'd0, bus.ex_allowin_o}, 32'd0);
                checkOutput("stall hold valid", {31'd0, bus.ex_to_mem_valid_o}, 32'd1);
            end
            bus.mem_allowin_i = 1'b1;
            #1;
            checkOutput("release allowin", {31'd0, bus.ex_allowin_o}, 32'd1);
            nextCycle();
            waitValid(40, seen, res, hi);
            checkOutput("back-to-back latency", seen, 32'd33);
            checkOutput("back-to-back result", res, 32'hFFFF_FFFD);
            nextCycle();
            applyStimulus(1'b0, 1'b1, 1'b0, OP_ADD, 32'd0, 32'd0);
            nextCycle();

            // Flush at CALC counter 10 (cycle 11 after the op is first seen).
            applyStimulus(1'b1, 1'b1, 1'b0, OP_DIVWU, 32'd1000, 32'd3);
            validCount = 0;
            for (int k = 0; k < 11; k++) begin
                @(negedge clk);
                if (bus.ex_to_mem_valid_o) validCount++;
                nextCycle();
            end
            applyStimulus(1'b1, 1'b1, 1'b1, OP_DIVWU, 32'd1000, 32'd3);
            @(negedge clk);
            checkOutput("flush cycle valid", {31'd0, bus.ex_to_mem_valid_o}, 32'd0);
            checkOutput("flush cycle allowin", {31'd0, bus.ex_allowin_o}, 32'd1);
            nextCycle();
            applyStimulus(1'b0, 1'b1, 1'b0, OP_DIVWU, 32'd1000, 32'd3);
            @(negedge clk);
            if (bus.ex_to_mem_valid_o) validCount++;
            checkOutput("post-flush allowin", {31'd0, bus.ex_allowin_o}, 32'd1);
            checkOutput("flushed op never valid", validCount, 32'd0);
            nextCycle();
            applyStimulus(1'b1, 1'b1, 1'b0, OP_DIVWU, 32'd1000, 32'd3);
            waitValid(40, seen, res, hi);
            checkOutput("after flush latency", seen, 32'd33);
            checkOutput("after flush result", res, 32'd333);
            nextCycle();
            applyStimulus(1'b0, 1'b1, 1'b0, OP_ADD, 32'd0, 32'd0);
            nextCycle();

            // Reset mid-CALC abandons the op; a fresh start takes full latency.
            applyStimulus(1'b1, 1'b1, 1'b0, OP_DIVW, 32'd50, 32'd7);
            repeat (6) nextCycle();
            rst_n = 1'b0;
            @(negedge clk);
            checkOutput("reset in calc valid", {31'd0, bus.ex_to_mem_valid_o}, 32'd0);
            nextCycle();
            rst_n = 1'b1;
            waitValid(40, seen, res, hi);
            checkOutput("after reset latency", seen, 32'd33);
            checkOutput("after reset result", res, 32'd7);
            nextCycle();
            applyStimulus(1'b0, 1'b1, 1'b0, OP_ADD, 32'd0, 32'd0);
            nextCycle();
        end
`else
        // Divider not built: divide opcodes are single-cycle with zero result.
        aluCase("MOD.W 9/4 nodiv", OP_MODW, 32'd9, 32'd4, 32'd0);
        aluCase("DIV.WU 100/0 nodiv", OP_DIVWU, 32'd100, 32'd0, 32'd0);
        aluCase("DIV.W nodiv", OP_DIVW, 32'hFFFF_FFF9, 32'd2, 32'd0);
        aluCase("MOD.WU nodiv", OP_MODWU, 32'd100, 32'd7, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have these ports (name direction width meaning):
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ex_valid_i  in  1  EX holds a valid instruction, from the ID/EX register.
- mem_allowin_i  in  1  MEM stage can accept data this cycle.
- flush_i  in  1  pipeline flush; aborts EX work.
- pc_i  in  32  instruction PC.
- alu_op_i  in  4  operation code (REQ-005).
- src1_i, src2_i  in  32 each  operands.
- dest_i  in  5  destination GPR.
- gr_we_i  in  1  GPR write enable.
- ex_allowin_o  out  1  EX can accept a new instruction next edge.
- ex_to_mem_valid_o  out  1  EX result valid toward the EX/MEM register.
- pc_o  out  32  pass-through of pc_i.
- dest_o  out  5  pass-through of dest_i.
- gr_we_o  out  1  pass-through of gr_we_i.
- result_o  out  32  operation result.

Function
REQ-002 ready_go SHALL be 1 for non-divide ops, and 1 for divide ops only in DONE.
REQ-003 ex_to_mem_valid_o SHALL equal ex_valid_i & ready_go & !flush_i.
REQ-004 ex_allowin_o SHALL equal !ex_valid_i | (ready_go & mem_allowin_i) | flush_i.
REQ-005 The alu_op_i encoding SHALL be: 0 ADD, 1 SUB, 2 SLT (signed), 3 SLTU, 4 AND, 5 OR, 6 NOR, 7 XOR, 8 SLL, 9 SRL, 10 SRA, 11 LUI (result=src2), 12 DIV.W, 13 MOD.W, 14 DIV.WU, 15 MOD.WU.
- Shift amount = src2_i[4:0].
- ADD and SUB wrap modulo 2^32.
- SLT and SLTU return 0 or 1.
REQ-006 Non-divide ops SHALL be combinational, with zero added latency.
REQ-007 The divider FSM SHALL have states IDLE, CALC and DONE.
- IDLE->CALC: ex_valid_i & div op & !flush_i; latch magnitudes and signs; counter=0.
- CALC: one restoring-division step per cycle; counter increments; counter==31 -> DONE.
- DONE->IDLE: mem_allowin_i | flush_i.
- DONE holds quotient and remainder stable while mem_allowin_i=0.
REQ-008 A divide op first seen in cycle 0 SHALL assert ex_to_mem_valid_o in cycle 33 (32 CALC cycles).
REQ-009 Signed divide results SHALL follow these rules.
- Quotient is negative iff operand signs differ.
- Remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0.
REQ-010 Divide by zero SHALL produce quotient 0xFFFFFFFF (unsigned and signed) and remainder = src1_i.
REQ-011 flush_i in any state SHALL force the FSM to IDLE on the next edge, and no result from that op SHALL be emitted.
REQ-012 In DONE, a new divide op SHALL be accepted only after the DONE->IDLE transition.
- Back-to-back divides each take the full latency.
REQ-013 pc_o, dest_o and gr_we_o SHALL be combinational copies of their inputs.

Reset
REQ-014 While rst_n=0 at a clock edge, the following SHALL be cleared: state=IDLE, counter=0, quotient and remainder registers=0.
REQ-015 With ex_valid_i=0 after reset, outputs SHALL be ex_allowin_o=1 and ex_to_mem_valid_o=0.
REQ-016 Reset asserted during CALC SHALL abandon the divide without producing output.

Configuration
REQ-017 Macro EX_DIV_EN SHALL control whether the divider is built.
- Defined: divider FSM built per REQ-007..012.
- Undefined: no divider logic; ops 12-15 give result_o=0 with ready_go=1 (single cycle).

Verification
REQ-018 ADD src1=0xFFFFFFFF, src2=1, ex_valid_i=1, mem_allowin_i=1 -> result_o=0, ex_to_mem_valid_o=1 in the same cycle.
REQ-019 DIV.W src1=-7 (0xFFFFFFF9), src2=2 -> cycle 33: result_o=0xFFFFFFFD. Same operands with MOD.W -> 0xFFFFFFFF.
REQ-020 DIV.WU src1=100, src2=0 -> cycle 33: result_o=0xFFFFFFFF. MOD.WU on the same operands -> 100.
REQ-021 DIV.W stalled in DONE with mem_allowin_i=0 for 5 cycles -> result_o stable, ex_allowin_o=0. Raise mem_allowin_i -> one transfer, then IDLE.
REQ-022 flush_i pulse at CALC counter=10 -> next cycle IDLE, ex_allowin_o=1, ex_to_mem_valid_o never asserted for that op.
REQ-023 Build without EX_DIV_EN: MOD.W 9,4 -> result_o=0 and ex_to_mem_valid_o=1 in the same cycle.
